// File: rtl/up_down_counter.sv
// up_down_counter
//   Synchronous modulo-2^WIDTH binary up/down counter. On each rising edge of clk, the
//   count moves by exactly one step. Reset returns it to zero. Both terminal flags are
//   decoded directly from the count register.
//
// Parameters
//   WIDTH    counter width in bits, 1..32
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   reset    synchronous active-high clear; has priority over counting
//   up_down  direction: 1 = +1, 0 = -1 (wraps in both directions)
//   count    counter register value
//   at_max   count == all ones
//   at_min   count == 0
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;

  // Modulo arithmetic comes for free from the fixed register width. The counter
  // never holds, so there is no enable term.
  always_comb begin
    count_nxt = up_down ? (count + STEP) : (count - STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  // The flags are pure decodes of the register, so they change exactly when count does.
  assign at_max = &count;
  assign at_min = ~|count;

endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter
//   Directed walk through the reference scenarios, followed by a randomized
//   reset/direction sequence. Every edge is checked against an integer modulo model.
module tb_up_down_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic             up_down;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;

  int tests;
  int fails;
  int model;   // expected count as a plain integer in 0..MOD-1

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .up_down (up_down),
    .count   (count),
    .at_max  (at_max),
    .at_min  (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;   // rising edges at 5, 15, 25, ... ns

  task automatic chk_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Compare count and both flags against the model.
  task automatic chk_all(input string tag);
    logic [WIDTH-1:0] exp_cnt;
    exp_cnt = WIDTH'(model);
    chk_val({tag, ".count"}, count, exp_cnt);
    chk_bit({tag, ".at_max"}, at_max, (model == MOD - 1));
    chk_bit({tag, ".at_min"}, at_min, (model == 0));
  endtask

  // Drive the inputs at the falling edge, let one rising edge pass, advance the model,
  // then sample 1 ns after that edge.
  task automatic step(input logic r, input logic ud, input string tag);
    @(negedge clk);
    reset   = r;
    up_down = ud;
    @(posedge clk);
    #1;
    if (r)       model = 0;
    else if (ud) model = (model + 1) % MOD;
    else         model = (model + MOD - 1) % MOD;
    chk_all(tag);
  endtask

  initial begin
    int start;
    tests   = 0;
    fails   = 0;
    model   = 0;
    reset   = 1'b1;
    up_down = 1'b1;

    // 1. Reset at the 5 ns edge, then count up to 7.
    @(posedge clk);
    #1;
    chk_all("reset_5ns");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "count_up");
    chk_val("up_reaches_7", count, 4'd7);

    // 2. Change direction: the count goes 6, 5, 4, 3, 2.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "count_down");
    chk_val("down_reaches_2", count, 4'd2);

    // 3. Reset in the middle of a count.
    step(1'b1, 1'b0, "mid_reset");
    chk_bit("mid_reset_at_min", at_min, 1'b1);

    // 4. Down wrap from 0 to 15, then 14.
    step(1'b0, 1'b0, "down_wrap");
    chk_val("down_wrap_15", count, 4'd15);
    chk_bit("down_wrap_at_max", at_max, 1'b1);
    step(1'b0, 1'b0, "down_after_wrap");
    chk_val("down_wrap_14", count, 4'd14);

    // 5. Up wrap: 15, 0, 1, 2.
    step(1'b0, 1'b1, "up_to_15");
    chk_val("up_15", count, 4'd15);
    step(1'b0, 1'b1, "up_wrap");
    chk_val("up_wrap_0", count, 4'd0);
    chk_bit("up_wrap_at_min", at_min, 1'b1);
    step(1'b0, 1'b1, "up_after_wrap1");
    step(1'b0, 1'b1, "up_after_wrap2");
    chk_val("up_after_wrap_2", count, 4'd2);

    // 6. Reset priority while up_down toggles, followed by full sweeps.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i[0], "reset_priority");
      chk_val("reset_hold_zero", count, 4'd0);
    end
    step(1'b0, 1'b1, "pre_sweep");
    start = model;
    for (int i = 0; i < MOD; i++) step(1'b0, 1'b1, "sweep_up");
    chk_val("sweep_up_return", count, WIDTH'(start));
    for (int i = 0; i < MOD; i++) step(1'b0, 1'b0, "sweep_down");
    chk_val("sweep_down_return", count, WIDTH'(start));

    // Randomized reset and direction, with reset asserted about 1 cycle in 8.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Backstop: the run ends on its own even if the sequence above stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
